// File: rtl/draw_enemies_pkg.sv
// Shared definitions for the enemy-drawing phase.
// Holds the enemy record layout, the screen geometry, the 3-3-3 colour
// constants and the FSM state encoding used by draw_enemies.
package draw_enemies_pkg;

    // Enemy table record: [23] active, [22:7] world_x tile, [6:0] y pixel
    localparam int ACTIVE_BIT = 23;
    localparam int WX_MSB     = 22;
    localparam int WX_LSB     = 7;
    localparam int Y_MSB      = 6;

    // Screen geometry in pixels
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int TILE_PX  = 8;

    // 3-3-3 RGB colours
    localparam logic [8:0] COLOR_BLACK = 9'b000000000;
    localparam logic [8:0] COLOR_RED   = 9'b111000000;
    localparam logic [8:0] COLOR_WHITE = 9'b111111111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_EVAL     = 3'd3,
        S_DRAW     = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/draw_enemies_if.sv
// Handshake, enemy-table and pixel-plot bundle between the main state
// machine side (master) and the enemy drawer (slave).
//   enable, x_offset     : phase enable and scroll position (master -> slave)
//   enemy_address/_data  : enemy table read port, 1-cycle read latency
//   x, y, color, plot    : pixel write interface shared with the other drawers
//   done                 : phase complete (slave -> master)
interface draw_enemies_if #(
    parameter int ADDR_W = 3
) ();
    logic              enable;
    logic [31:0]       x_offset;
    logic [ADDR_W-1:0] enemy_address;
    logic [23:0]       enemy_data;
    logic [7:0]        x;
    logic [6:0]        y;
    logic [8:0]        color;
    logic              plot;
    logic              done;

    modport master (
        output enable, x_offset, enemy_data,
        input  enemy_address, x, y, color, plot, done
    );

    modport slave (
        input  enable, x_offset, enemy_data,
        output enemy_address, x, y, color, plot, done
    );
endinterface

// File: rtl/draw_enemies_enemy_block_scanner.sv
// Column/row counter pair walking one enemy block in raster order.
//   clock, resetn : clock and async active-low reset
//   start_i       : clear to pixel (0,0)
//   step_i        : advance one pixel, column first, then row
//   col_o, row_o  : current pixel within the block
//   last_o        : current pixel is the bottom-right one
module enemy_block_scanner #(
    parameter int BLOCK_W = 8,
    parameter int BLOCK_H = 8,
    parameter int COL_W   = 3,
    parameter int ROW_W   = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             step_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             last_o
);
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             col_end_s;
    logic             row_end_s;

    assign col_end_s = (col_q == COL_W'(BLOCK_W - 1));
    assign row_end_s = (row_q == ROW_W'(BLOCK_H - 1));

    // Raster counter: start wins over step, column wraps into row
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else if (start_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step_i) begin
            if (col_end_s) begin
                col_q <= '0;
                row_q <= row_end_s ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end else begin
            col_q <= col_q;
            row_q <= row_q;
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = col_end_s && row_end_s;
endmodule

// File: rtl/draw_enemies.sv
// Enemy-drawing phase responder for the main FSM enable/done handshake.
// Walks the enemy table, culls entries outside the 20-tile scroll window
// and plots each visible enemy as a solid block, one pixel per cycle.
//   clock, resetn : clock and async active-low reset
//   bus (slave)   : enable/x_offset in, enemy table port, x/y/color/plot out,
//                   done out
module draw_enemies #(
    parameter int         NUM_ENEMIES  = 8,
    parameter int         ADDR_W       = 3,
    parameter int         ENEMY_W      = 8,
    parameter int         ENEMY_H      = 8,
    parameter logic [8:0] ENEMY_COLOR  = 9'b111000000,
    parameter int         SCREEN_TILES = 20,
    parameter int         SCREEN_H     = 120
) (
    input  logic           clock,
    input  logic           resetn,
    draw_enemies_if.slave  bus
);
    import draw_enemies_pkg::*;

    localparam int COL_W = (ENEMY_W > 1) ? $clog2(ENEMY_W) : 1;
    localparam int ROW_W = (ENEMY_H > 1) ? $clog2(ENEMY_H) : 1;

    state_t            state_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        base_x_q;
    logic [6:0]        base_y_q;
    logic [7:0]        x_q;
    logic [6:0]        y_q;
    logic [8:0]        color_q;
    logic              plot_q;
    logic              done_q;

    logic              rec_active_s;
    logic [15:0]       rec_wx_s;
    logic [6:0]        rec_y_s;
    logic [31:0]       diff_s;
    logic              visible_s;
    logic [7:0]        eval_x_s;
    logic              eval_plot_s;

    logic              scan_start_s;
    logic              scan_step_s;
    logic [COL_W-1:0]  col_s;
    logic [ROW_W-1:0]  row_s;
    logic              last_s;

    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic [7:0]        x_d;
    logic [7:0]        y_sum_d;
    logic              plot_d;

    assign scan_start_s = (state_q == S_EVAL);
    assign scan_step_s  = (state_q == S_DRAW);

    enemy_block_scanner #(
        .BLOCK_W (ENEMY_W),
        .BLOCK_H (ENEMY_H),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_scanner (
        .clock   (clock),
        .resetn  (resetn),
        .start_i (scan_start_s),
        .step_i  (scan_step_s),
        .col_o   (col_s),
        .row_o   (row_s),
        .last_o  (last_s)
    );

    // Record decode and window cull; a negative difference wraps high and fails
    always_comb begin
        rec_active_s = bus.enemy_data[ACTIVE_BIT];
        rec_wx_s     = bus.enemy_data[WX_MSB:WX_LSB];
        rec_y_s      = bus.enemy_data[Y_MSB:0];
        diff_s       = {16'b0, rec_wx_s} - bus.x_offset;
        visible_s    = rec_active_s && (diff_s < 32'(SCREEN_TILES));
        eval_x_s     = {diff_s[4:0], 3'b000};
        eval_plot_s  = ({1'b0, rec_y_s} < 8'(SCREEN_H));
    end

    // Pixel that follows the one currently on the outputs, so that the
    // registered outputs line up exactly with the DRAW cycles
    always_comb begin
        col_d = '0;
        row_d = '0;
        if (col_s == COL_W'(ENEMY_W - 1)) begin
            col_d = '0;
            row_d = row_s + ROW_W'(1);
        end else begin
            col_d = col_s + COL_W'(1);
            row_d = row_s;
        end
        x_d     = base_x_q + 8'(col_d);
        y_sum_d = {1'b0, base_y_q} + 8'(row_d);
        plot_d  = (y_sum_d < 8'(SCREEN_H));
    end

    // Phase FSM with registered pixel and handshake outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            addr_q   <= '0;
            base_x_q <= 8'd0;
            base_y_q <= 7'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            color_q  <= COLOR_BLACK;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if ((state_q != S_IDLE) && !bus.enable) begin
            // Enable dropped mid-phase: abandon the frame, no resume
            state_q <= S_IDLE;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    plot_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.enable) begin
                        index_q <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    addr_q  <= index_q;
                    state_q <= S_WAIT_MEM;
                end
                S_WAIT_MEM: begin
                    state_q <= S_EVAL;
                end
                S_EVAL: begin
                    if (visible_s) begin
                        base_x_q <= eval_x_s;
                        base_y_q <= rec_y_s;
                        x_q      <= eval_x_s;
                        y_q      <= rec_y_s;
                        color_q  <= ENEMY_COLOR;
                        plot_q   <= eval_plot_s;
                        state_q  <= S_DRAW;
                    end else begin
                        state_q  <= S_NEXT;
                    end
                end
                S_DRAW: begin
                    if (last_s) begin
                        plot_q  <= 1'b0;
                        state_q <= S_NEXT;
                    end else begin
                        x_q    <= x_d;
                        y_q    <= y_sum_d[6:0];
                        plot_q <= plot_d;
                    end
                end
                S_NEXT: begin
                    if (index_q == ADDR_W'(NUM_ENEMIES - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        index_q <= index_q + ADDR_W'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    plot_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                default: begin
                    plot_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.enemy_address = addr_q;
    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.color         = color_q;
    assign bus.plot          = plot_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_draw_enemies.sv
// Directed bench for draw_enemies: a behavioural 1-cycle-latency enemy
// table feeds the DUT, and each frame's plotted pixels are summarised
// (count, x/y extents, colour) and compared against hand-derived values.
module tb_draw_enemies;
    logic clk;
    logic rst_n;

    int checks;
    int fails;

    logic [23:0] mem [0:7];

    draw_enemies_if #(.ADDR_W(3)) bus ();

    draw_enemies dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous enemy table, one-cycle read latency
    always @(posedge clk) bus.enemy_data <= mem[bus.enemy_address];

    function automatic logic [23:0] rec(input logic act, input logic [15:0] wx,
                                        input logic [6:0] yp);
        return {act, wx, yp};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 24'd0;
    endtask

    // Runs one full frame and checks its pixel summary and done timing
    task automatic run_frame(input string tag, input int exp_plots,
                             input int exp_xmin, input int exp_xmax,
                             input int exp_ymin, input int exp_ymax,
                             input int exp_cycles);
        int cycles;
        int plots;
        int xmin, xmax, ymin, ymax;
        int bad_color;
        int overlap;
        logic got_done;
        cycles = 0; plots = 0; bad_color = 0; overlap = 0;
        xmin = 1000; xmax = -1; ymin = 1000; ymax = -1;
        got_done = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            cycles++;
            if (bus.plot === 1'b1) begin
                plots++;
                if (int'(bus.x) < xmin) xmin = int'(bus.x);
                if (int'(bus.x) > xmax) xmax = int'(bus.x);
                if (int'(bus.y) < ymin) ymin = int'(bus.y);
                if (int'(bus.y) > ymax) ymax = int'(bus.y);
                if (bus.color !== 9'b111000000) bad_color++;
                if (bus.done === 1'b1) overlap++;
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, 32'(got_done), 32'd1);
        check({tag, " done_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({tag, " plots"}, 32'(plots), 32'(exp_plots));
        if (exp_plots > 0) begin
            check({tag, " xmin"}, 32'(xmin), 32'(exp_xmin));
            check({tag, " xmax"}, 32'(xmax), 32'(exp_xmax));
            check({tag, " ymin"}, 32'(ymin), 32'(exp_ymin));
            check({tag, " ymax"}, 32'(ymax), 32'(exp_ymax));
        end
        check({tag, " color"}, 32'(bad_color), 32'd0);
        check({tag, " done_with_plot"}, 32'(overlap), 32'd0);
        // done holds while enable stays high
        repeat (3) @(negedge clk);
        check({tag, " done_hold"}, 32'(bus.done), 32'd1);
        check({tag, " plot_in_done"}, 32'(bus.plot), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        check({tag, " done_drop"}, 32'(bus.done), 32'd0);
    endtask

    // Enables a frame and waits (bounded) until the first plotted pixel
    task automatic start_until_plot(input string tag, output int done_seen);
        logic seen;
        seen = 1'b0;
        done_seen = 0;
        @(negedge clk);
        bus.enable = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
            if (bus.plot === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " plot_started"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int dseen;
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.enable   = 1'b0;
        bus.x_offset = 32'd0;
        clear_mem();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst plot", 32'(bus.plot), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst x", 32'(bus.x), 32'd0);
        check("rst y", 32'(bus.y), 32'd0);
        check("rst color", 32'(bus.color), 32'd0);
        check("rst addr", 32'(bus.enemy_address), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single visible enemy: diff 5 -> x 40..47, y 40..47
        clear_mem();
        mem[0] = rec(1'b1, 16'd25, 7'd40);
        bus.x_offset = 32'd20;
        run_frame("single", 64, 40, 47, 40, 47, 97);

        // Culling: negative diff, diff == 20, inactive but in-window entry
        clear_mem();
        mem[0] = rec(1'b1, 16'd19, 7'd40);
        mem[1] = rec(1'b1, 16'd40, 7'd10);
        mem[2] = rec(1'b0, 16'd22, 7'd10);
        run_frame("cull", 0, 0, 0, 0, 0, 33);

        // Vertical clip: rows 115..119 only
        clear_mem();
        mem[5] = rec(1'b1, 16'd20, 7'd115);
        run_frame("vclip", 40, 0, 7, 115, 119, 97);

        // Right edge: diff 19 -> x 152..159
        clear_mem();
        mem[0] = rec(1'b1, 16'd39, 7'd0);
        run_frame("redge", 64, 152, 159, 0, 7, 97);

        // Large scroll offset using the upper world_x bits
        clear_mem();
        mem[7] = rec(1'b1, 16'd1005, 7'd60);
        bus.x_offset = 32'd1000;
        run_frame("bigoff", 64, 40, 47, 60, 67, 97);

        // Abort during DRAW of enemy 3
        clear_mem();
        mem[3] = rec(1'b1, 16'd22, 7'd20);
        bus.x_offset = 32'd20;
        start_until_plot("abort", dseen);
        repeat (5) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort plot", 32'(bus.plot), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort done_before", 32'(dseen), 32'd0);
        repeat (3) @(negedge clk);
        check("abort idle_plot", 32'(bus.plot), 32'd0);
        // Restart covers all eight entries again, so full frame timing
        run_frame("restart", 64, 16, 23, 20, 27, 97);

        // Asynchronous reset while plotting
        start_until_plot("rstmid", dseen);
        repeat (3) @(negedge clk);
        check("rstmid x_before", 32'(bus.x), 32'd19);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid plot", 32'(bus.plot), 32'd0);
        check("rstmid done", 32'(bus.done), 32'd0);
        check("rstmid x", 32'(bus.x), 32'd0);
        check("rstmid y", 32'(bus.y), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst plot", 32'(bus.plot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/draw_enemies.md
Name: draw_enemies

Overview:
- Responder to the main state machine's enable/done handshake for the enemy-drawing phase, in the slot currently occupied by the constant done tie-off.
- On enable, walks an enemy table held in synchronous memory (1-cycle read latency, same style as the level memory) and culls enemies outside the current 20-tile window.
- Plots each visible enemy as a solid ENEMY_W x ENEMY_H block, one pixel per cycle, on the same x/y/color/plot interface used by the background and character drawers.

Parameters:
- NUM_ENEMIES, 8, number of table entries scanned per frame.
- ADDR_W, 3, width of enemy_address; requires 2**ADDR_W >= NUM_ENEMIES.
- ENEMY_W, 8, block width in pixels (one tile).
- ENEMY_H, 8, block height in pixels.
- ENEMY_COLOR, 9'b111000000, 3-3-3 RGB colour of every plotted pixel.
- SCREEN_TILES, 20, visible width in tiles (160/8).
- SCREEN_H, 120, visible height in pixels.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  held high by the main FSM for the whole DRAW_ENEMIES phase.
- x_offset  in  32  level scroll position in tiles (x_tile_position).
- enemy_address  out  ADDR_W  enemy table read address.
- enemy_data  in  24  record returned one cycle after the address: [23] active, [22:7] world_x tile, [6:0] y pixel.
- x  out  8  screen pixel x.
- y  out  7  screen pixel y.
- color  out  9  pixel colour.
- plot  out  1  pixel write strobe.
- done  out  1  phase complete.

Behaviour:
- Reset (async, resetn=0): state IDLE; enemy_address=0, x=0, y=0, color=0, plot=0, done=0; all counters cleared. Reset mid-draw aborts immediately.
- States: IDLE, FETCH, WAIT_MEM, EVAL, DRAW, NEXT, DONE.
- IDLE: when enable=1, go to FETCH with index=0.
- FETCH: drive enemy_address=index, then go to WAIT_MEM.
- WAIT_MEM: hold enemy_address for the memory's 1-cycle latency.
- EVAL: register enemy_data.
  - diff = {16'b0, world_x} - x_offset, computed 32-bit unsigned. Negative results wrap to large values and so fail the test below.
  - Visible when active=1 and diff < SCREEN_TILES.
  - If visible: base_x = diff[4:0]*8 (8-bit), base_y = y field, col=0, row=0, go to DRAW.
  - Otherwise go to NEXT.
- DRAW: one pixel per cycle.
  - x = base_x+col, y = base_y+row, color = ENEMY_COLOR.
  - plot=1, except when base_y+row >= SCREEN_H (computed 8-bit, no wrap), where plot=0 (vertical clip).
  - col increments first; at col=ENEMY_W-1, col wraps to 0 and row increments.
  - After pixel (ENEMY_W-1, ENEMY_H-1), go to NEXT.
  - Exactly ENEMY_W*ENEMY_H cycles per visible enemy.
- NEXT: if index=NUM_ENEMIES-1, go to DONE; otherwise increment index and go to FETCH.
- DONE: done=1, plot=0. Stay while enable=1; return to IDLE when enable=0. done deasserts in the cycle after enable falls.
- enable=0 in any non-IDLE state: abort to IDLE next cycle, plot=0, done=0. There is no partial-frame resume.
- plot, x, y and color are registered outputs. plot=0 in every state except DRAW.
- Worst-case phase length: NUM_ENEMIES*(4 + ENEMY_W*ENEMY_H) + 1 cycles, i.e. 545 with defaults. This fits easily in the 60 fps budget.
- done never asserts while plot=1.

Decomposition:
- Shared package holds:
  - the enemy record field positions (ACTIVE_BIT=23, WX_MSB=22, WX_LSB=7, Y_MSB=6);
  - SCREEN_W=160, SCREEN_H=120, TILE_PX=8;
  - the 9-bit colour constants.
- One sub-module, enemy_block_scanner: the col/row counter pair.
  - Inputs: start, step.
  - Outputs: col, row, last.
  - The FSM instantiates it once.

Test Plan:
- Single enemy: entry 0 = {1, world_x=25, y=40}, x_offset=20, others inactive; assert enable.
  - Expect 64 plots covering x 40..47, y 40..47, color 9'b111000000.
  - Expect done=1 after 8*4 + 64 cycles of work; done drops one cycle after enable falls.
- Culling: world_x=19 with x_offset=20 (negative diff), world_x=40 (diff=20), and active=0 entries.
  - Expect zero plots and done after 8*4 cycles.
- Vertical clip: y=115, diff=0.
  - Expect 64 DRAW cycles, plot=1 only for rows 115..119 (40 pixels), x 0..7.
- Right edge: diff=19.
  - Expect x range 152..159 with no wrap.
- Abort: deassert enable during DRAW of enemy 3.
  - Expect plot=0 on the next cycle, state IDLE, done never asserted.
  - Re-asserting enable restarts from index 0.
- Reset mid-draw: resetn=0 asynchronously while plot=1.
  - Expect plot=0, done=0, x=0, y=0 immediately, without waiting for a clock edge.
